// File: rtl/tensor_octet_mw.sv
// Tensor-core octet operand collector and result serializer.
// Pairs per-warp HMMA beats into DPU tiles; streams results back to lanes.
module tensor_octet_mw #(
    parameter int NUM_WARPS = 4,
    parameter int WID_W     = 2,
    parameter int RES_DEPTH = 2,
    parameter int WB_BEATS  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WID_W-1:0]  in_wid,
    input  logic [1:0]        in_step,
    input  logic [8*32-1:0]   in_a,
    input  logic [8*32-1:0]   in_b,
    input  logic [8*32-1:0]   in_c,
    output logic              dpu_valid,
    input  logic              dpu_ready,
    output logic [WID_W-1:0]  dpu_wid,
    output logic [4*2*32-1:0] dpu_a,
    output logic [2*4*32-1:0] dpu_b,
    output logic [4*4*32-1:0] dpu_c,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [WID_W-1:0]  res_wid,
    input  logic [4*4*32-1:0] res_d,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WID_W-1:0]  out_wid,
    output logic [8*32-1:0]   out_data,
    output logic              out_beat,
    output logic              out_last
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);

    if (WB_BEATS != 2) begin : g_bad_beats
        $error("tensor_octet_mw: WB_BEATS must be 2");
    end
    if (WID_W < 1 || (1 << WID_W) < NUM_WARPS) begin : g_bad_wid
        $error("tensor_octet_mw: WID_W too narrow for NUM_WARPS");
    end

    typedef logic [3:0][31:0]  half_t;
    typedef logic [7:0][31:0]  oct_t;
    typedef logic [15:0][31:0] tile_t;

    oct_t  la, lb, lc;
    half_t a_half, b_half;

    assign la = in_a;
    assign lb = in_b;
    assign lc = in_c;

    assign a_half = in_step[0] ? {la[7], la[6], la[3], la[2]}
                               : {la[5], la[4], la[1], la[0]};
    assign b_half = in_step[1] ? lb[7:4] : lb[3:0];

    logic [NUM_WARPS-1:0] pending;
    half_t slot_a [NUM_WARPS];
    half_t slot_b [NUM_WARPS];
    oct_t  slot_c [NUM_WARPS];

    logic cur_pend;
    logic in_fire;

    assign cur_pend  = pending[in_wid];
    assign in_ready  = cur_pend ? dpu_ready : 1'b1;
    assign in_fire   = in_valid && in_ready;
    assign dpu_valid = in_valid && cur_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else if (in_fire) begin
            pending[in_wid] <= !cur_pend;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire && !cur_pend) begin
            slot_a[in_wid] <= a_half;
            slot_b[in_wid] <= b_half;
            slot_c[in_wid] <= lc;
        end
    end

    half_t fa, fb;
    oct_t  fc;
    oct_t  tile_a, tile_b;
    tile_t tile_c;

    assign fa = slot_a[in_wid];
    assign fb = slot_b[in_wid];
    assign fc = slot_c[in_wid];

    for (genvar gr = 0; gr < 4; gr++) begin : g_ab
        assign tile_a[2*gr]   = fa[gr];
        assign tile_a[2*gr+1] = a_half[gr];
        assign tile_b[gr]     = fb[gr];
        assign tile_b[4+gr]   = b_half[gr];
    end

    // Even C columns come from the first beat, odd ones from the second.
    for (genvar gr = 0; gr < 4; gr++) begin : g_cr
        for (genvar gc = 0; gc < 4; gc++) begin : g_cc
            localparam int L = (gr % 2) + 4 * (gr / 2) + 2 * (gc / 2);
            if (gc % 2 == 0) begin : g_ev
                assign tile_c[4*gr+gc] = fc[L];
            end else begin : g_od
                assign tile_c[4*gr+gc] = lc[L];
            end
        end
    end

    assign dpu_wid = dpu_valid ? in_wid : '0;
    assign dpu_a   = dpu_valid ? tile_a : '0;
    assign dpu_b   = dpu_valid ? tile_b : '0;
    assign dpu_c   = dpu_valid ? tile_c : '0;

    logic [WID_W-1:0] fifo_w [RES_DEPTH];
    tile_t            fifo_d [RES_DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             bcnt;
    logic             full, empty, push, pop, last_beat;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (count == CW'(RES_DEPTH));
    assign empty     = (count == '0);
    assign res_ready = !full;
    assign push      = res_valid && !full;
    assign out_valid = !empty;
    assign last_beat = (bcnt == 1'(WB_BEATS - 1));
    assign pop       = out_valid && out_ready && last_beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            bcnt   <= 1'b0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            if (push && !pop) count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (out_valid && out_ready) bcnt <= last_beat ? 1'b0 : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_w[wr_ptr] <= res_wid;
            fifo_d[wr_ptr] <= res_d;
        end
    end

    tile_t hd;
    oct_t  ol;

    assign hd = fifo_d[rd_ptr];

    for (genvar gl = 0; gl < 8; gl++) begin : g_ol
        localparam int R = (gl % 2) + 2 * (gl / 4);
        localparam int J = (gl / 2) % 2;
        assign ol[gl] = bcnt ? hd[4*R+2*J+1] : hd[4*R+2*J];
    end

    assign out_data = out_valid ? ol : '0;
    assign out_wid  = out_valid ? fifo_w[rd_ptr] : '0;
    assign out_beat = bcnt;
    assign out_last = last_beat;

endmodule

// File: tb/tb_tensor_octet_mw.sv
// Directed bench for tensor_octet_mw: tile assembly, interleave,
// backpressure, serialization, FIFO full and mid-tile reset.
module tb_tensor_octet_mw;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_wid;
    logic [1:0]   in_step;
    logic [255:0] in_a, in_b, in_c;
    logic         dpu_valid;
    logic         dpu_ready;
    logic [1:0]   dpu_wid;
    logic [255:0] dpu_a, dpu_b;
    logic [511:0] dpu_c;
    logic         res_valid;
    logic         res_ready;
    logic [1:0]   res_wid;
    logic [511:0] res_d;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_wid;
    logic [255:0] out_data;
    logic         out_beat;
    logic         out_last;

    tensor_octet_mw dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_wid(in_wid), .in_step(in_step),
        .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .dpu_valid(dpu_valid), .dpu_ready(dpu_ready),
        .dpu_wid(dpu_wid), .dpu_a(dpu_a),
        .dpu_b(dpu_b), .dpu_c(dpu_c),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_wid(res_wid), .res_d(res_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wid(out_wid), .out_data(out_data),
        .out_beat(out_beat), .out_last(out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int issues = 0;

    always @(posedge clk)
        if (!reset && dpu_valid && dpu_ready) issues <= issues + 1;

    typedef struct {
        logic [1:0]  wid;
        logic [1:0]  s0;
        logic [1:0]  s1;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] l0;
        logic [31:0] l7;
        logic [1:0]  wid;
        logic        beat;
        logic        last;
        logic        rr;
    } drn_t;

    vec_t vt [16];
    drn_t dt [4];

    logic         cap_dv, cap_rdy, cap_rr;
    logic [1:0]   cap_wid;
    logic [255:0] cap_a, cap_b;
    logic [511:0] cap_c;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input logic [31:0] base);
        logic [255:0] v;
        for (int l = 0; l < 8; l++) v[32*l +: 32] = base + 32'(l);
        return v;
    endfunction

    function automatic logic [511:0] dmat(input logic [31:0] base);
        logic [511:0] v;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                v[(4*r+c)*32 +: 32] = base + 32'(16*r+c);
        return v;
    endfunction

    task automatic beat(input logic [1:0] w, input logic [1:0] s,
                        input logic [31:0] ab, input logic [31:0] bb,
                        input logic [31:0] cb);
        @(negedge clk);
        in_valid = 1'b1;
        in_wid   = w;
        in_step  = s;
        in_a     = pat(ab);
        in_b     = pat(bb);
        in_c     = pat(cb);
        #1;
        cap_dv  = dpu_valid;
        cap_rdy = in_ready;
        cap_wid = dpu_wid;
        cap_a   = dpu_a;
        cap_b   = dpu_b;
        cap_c   = dpu_c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_res(input logic [1:0] w, input logic [31:0] base);
        @(negedge clk);
        res_valid = 1'b1;
        res_wid   = w;
        res_d     = dmat(base);
        #1;
        cap_rr = res_ready;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_dpu_valid"}, dpu_valid, 0);
        chk({tag, "_res_ready"}, res_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_beat"}, out_beat, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_wid"}, out_wid, 0);
        chk({tag, "_dpu_a"}, dpu_a, 0);
        chk({tag, "_dpu_c"}, dpu_c, 0);
    endtask

    initial begin
        vt[0]  = '{2'd1, 2'd0, 2'd0, 0, 0,  32'h10};
        vt[1]  = '{2'd1, 2'd0, 2'd0, 0, 1,  32'h110};
        vt[2]  = '{2'd1, 2'd0, 2'd0, 1, 6,  32'h122};
        vt[3]  = '{2'd1, 2'd0, 2'd0, 2, 1,  32'h130};
        vt[4]  = '{2'd1, 2'd0, 2'd0, 2, 10, 32'h36};
        vt[5]  = '{2'd0, 2'd1, 2'd3, 0, 7,  32'h117};
        vt[6]  = '{2'd0, 2'd1, 2'd3, 0, 6,  32'h17};
        vt[7]  = '{2'd0, 2'd1, 2'd3, 1, 3,  32'h23};
        vt[8]  = '{2'd0, 2'd1, 2'd3, 1, 5,  32'h125};
        vt[9]  = '{2'd3, 2'd2, 2'd1, 0, 4,  32'h14};
        vt[10] = '{2'd3, 2'd2, 2'd1, 0, 5,  32'h116};
        vt[11] = '{2'd3, 2'd2, 2'd1, 1, 0,  32'h24};
        vt[12] = '{2'd3, 2'd2, 2'd1, 1, 7,  32'h123};
        vt[13] = '{2'd2, 2'd0, 2'd0, 2, 15, 32'h137};
        vt[14] = '{2'd2, 2'd0, 2'd0, 2, 4,  32'h31};
        vt[15] = '{2'd2, 2'd0, 2'd0, 2, 14, 32'h37};

        dt[0] = '{32'h100, 32'h132, 2'd1, 1'b0, 1'b0, 1'b0};
        dt[1] = '{32'h101, 32'h133, 2'd1, 1'b1, 1'b1, 1'b0};
        dt[2] = '{32'h200, 32'h232, 2'd3, 1'b0, 1'b0, 1'b1};
        dt[3] = '{32'h201, 32'h233, 2'd3, 1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        in_valid = 1'b0; in_wid = '0; in_step = '0;
        in_a = '0; in_b = '0; in_c = '0;
        dpu_ready = 1'b1;
        res_valid = 1'b0; res_wid = '0; res_d = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_idle("rst");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [31:0] w;
            beat(vt[i].wid, vt[i].s0, 32'h10, 32'h20, 32'h30);
            chk($sformatf("v%0d_first_dv", i), cap_dv, 0);
            beat(vt[i].wid, vt[i].s1, 32'h110, 32'h120, 32'h130);
            chk($sformatf("v%0d_second_dv", i), cap_dv, 1);
            chk($sformatf("v%0d_wid", i), cap_wid, vt[i].wid);
            if (vt[i].sel == 0) w = cap_a[32*vt[i].idx +: 32];
            else if (vt[i].sel == 1) w = cap_b[32*vt[i].idx +: 32];
            else w = cap_c[32*vt[i].idx +: 32];
            chk($sformatf("v%0d_word", i), w, vt[i].exp);
        end

        beat(2'd0, 2'd0, 32'h1000, 32'h1100, 32'h1200);
        chk("il_w0b0_dv", cap_dv, 0);
        beat(2'd2, 2'd0, 32'h2000, 32'h2100, 32'h2200);
        chk("il_w2b0_dv", cap_dv, 0);
        beat(2'd2, 2'd0, 32'h2300, 32'h2400, 32'h2500);
        chk("il_w2_dv", cap_dv, 1);
        chk("il_w2_wid", cap_wid, 2);
        chk("il_w2_a0", cap_a[31:0], 32'h2000);
        chk("il_w2_a1", cap_a[63:32], 32'h2300);
        chk("il_w2_b4", cap_b[159:128], 32'h2400);
        chk("il_w2_c0", cap_c[31:0], 32'h2200);
        beat(2'd0, 2'd0, 32'h1300, 32'h1400, 32'h1500);
        chk("il_w0_dv", cap_dv, 1);
        chk("il_w0_wid", cap_wid, 0);
        chk("il_w0_a0", cap_a[31:0], 32'h1000);
        chk("il_w0_a1", cap_a[63:32], 32'h1300);
        chk("il_w0_c1", cap_c[63:32], 32'h1500);

        begin
            int snap;
            beat(2'd1, 2'd0, 32'h500, 32'h600, 32'h700);
            chk("bp_first_dv", cap_dv, 0);
            snap = issues;
            dpu_ready = 1'b0;
            @(negedge clk);
            in_valid = 1'b1; in_wid = 2'd1; in_step = 2'd0;
            in_a = pat(32'h800); in_b = pat(32'h900); in_c = pat(32'ha00);
            for (int k = 0; k < 3; k++) begin
                #1;
                chk($sformatf("bp_stall%0d_ready", k), in_ready, 0);
                chk($sformatf("bp_stall%0d_dv", k), dpu_valid, 1);
                @(negedge clk);
            end
            dpu_ready = 1'b1;
            #1;
            chk("bp_release_ready", in_ready, 1);
            chk("bp_a0", dpu_a[31:0], 32'h500);
            chk("bp_a1", dpu_a[63:32], 32'h800);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            #1;
            chk("bp_issue_count", 512'(issues - snap), 1);
            beat(2'd1, 2'd0, 32'h10, 32'h20, 32'h30);
            chk("bp_after_first_dv", cap_dv, 0);
            beat(2'd1, 2'd0, 32'h10, 32'h20, 32'h30);
            chk("bp_after_second_dv", cap_dv, 1);
        end

        out_ready = 1'b1;
        push_res(2'd2, 32'h0);
        chk("ser_res_ready", cap_rr, 1);
        chk("ser_b0_valid", out_valid, 1);
        chk("ser_b0_wid", out_wid, 2);
        chk("ser_b0_data", out_data,
            {32'h32, 32'h22, 32'h30, 32'h20, 32'h12, 32'h02, 32'h10, 32'h00});
        chk("ser_b0_beat", out_beat, 0);
        chk("ser_b0_last", out_last, 0);
        @(posedge clk);
        #1;
        chk("ser_b1_valid", out_valid, 1);
        chk("ser_b1_data", out_data,
            {32'h33, 32'h23, 32'h31, 32'h21, 32'h13, 32'h03, 32'h11, 32'h01});
        chk("ser_b1_beat", out_beat, 1);
        chk("ser_b1_last", out_last, 1);
        @(posedge clk);
        #1;
        chk("ser_empty", out_valid, 0);

        out_ready = 1'b0;
        push_res(2'd1, 32'h100);
        chk("full_push1_rr", cap_rr, 1);
        push_res(2'd3, 32'h200);
        chk("full_push2_rr", cap_rr, 1);
        @(negedge clk);
        res_valid = 1'b1; res_wid = 2'd0; res_d = dmat(32'h300);
        #1;
        chk("full_third_rr", res_ready, 0);
        chk("full_hold0_l0", out_data[31:0], 32'h100);
        res_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("full_hold1_l0", out_data[31:0], 32'h100);
        chk("full_hold1_beat", out_beat, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drn%0d_valid", k), out_valid, 1);
            chk($sformatf("drn%0d_l0", k), out_data[31:0], dt[k].l0);
            chk($sformatf("drn%0d_l7", k), out_data[255:224], dt[k].l7);
            chk($sformatf("drn%0d_wid", k), out_wid, dt[k].wid);
            chk($sformatf("drn%0d_beat", k), out_beat, dt[k].beat);
            chk($sformatf("drn%0d_last", k), out_last, dt[k].last);
            chk($sformatf("drn%0d_rr", k), res_ready, dt[k].rr);
            @(negedge clk);
        end
        #1;
        chk("drn_empty", out_valid, 0);

        beat(2'd3, 2'd0, 32'h40, 32'h50, 32'h60);
        chk("rs_w3_first_dv", cap_dv, 0);
        push_res(2'd1, 32'h400);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("rs_mid_beat", out_beat, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_idle("rs");
        beat(2'd3, 2'd1, 32'h70, 32'h80, 32'h90);
        chk("rs_w3_dv", cap_dv, 0);
        chk("rs_w3_ready", cap_rdy, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
